// File: rtl/vip_featuremap_pkg.sv
// Shared constants, types and float helpers for the feature-map ReLU + max-pool stage.
package vip_featuremap_pkg;

  localparam int          FP_SIGN_BIT = 31;
  localparam logic [31:0] FP_ZERO     = 32'h0;
  localparam int          FM_WIDTH    = 112;
  localparam int          FM_HEIGHT   = 112;

  typedef logic [31:0] fp32_t;

  // One captured pixel plus the position flags the pooling logic needs.
  typedef struct packed {
    logic  valid;
    logic  col_odd;
    logic  row_odd;
    logic  last;     // final pixel of the frame
    fp32_t px;       // already passed through ReLU
  } stage1_t;

  // Negative values, -0 and negative NaNs all clamp to +0.
  function automatic fp32_t relu_fp(input fp32_t x);
    return x[FP_SIGN_BIT] ? FP_ZERO : x;
  endfunction

  // Valid only for non-negative floats: their bit patterns order like unsigned integers.
  function automatic fp32_t max_nonneg_fp(input fp32_t a, input fp32_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vip_featuremap_line_buffer.sv
// Simple dual-port RAM holding one row of horizontal partial maxima.
module vip_featuremap_line_buffer
  import vip_featuremap_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = FM_WIDTH / 2,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;

  // Synchronous write and registered read.
  // NOTE: memory and its read register have no reset; every entry is written by an even row before an odd row reads it, so reset would only cost RAM inference.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q    <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vip_featuremap_relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 / stride-2 max-pool between two FIFOs.
// Pixel pipeline: pop (cycle t) -> data on in_rdata (t+1) -> stage 1 regs (t+2) -> output regs (t+3).
module vip_featuremap_relu_maxpool2x2
  import vip_featuremap_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = FM_WIDTH,
  parameter int HEIGHT = FM_HEIGHT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in_rdata,
  input  logic              in_empty,
  output logic              in_rdreq,
  output logic [DWIDTH-1:0] out_wdata,
  output logic              out_wrreq,
  input  logic              out_full,
  output logic              frame_done
);

  localparam int COL_W    = $clog2(WIDTH);
  localparam int ROW_W    = $clog2(HEIGHT);
  localparam int LB_DEPTH = WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic              rd_pend_q, rd_pend_d;   // a popped pixel is on in_rdata this cycle
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  stage1_t           s1_q, s1_d;
  logic [LB_AW-1:0]  s1_addr_q, s1_addr_d;
  fp32_t             h_q, h_d;               // ReLU'd even-column pixel awaiting its partner
  fp32_t             out_wdata_q, out_wdata_d;
  logic              out_wrreq_q, out_wrreq_d;
  logic              frame_done_q, frame_done_d;

  logic              col_last, row_last;
  logic [LB_AW-1:0]  lb_addr;
  fp32_t             hmax;
  fp32_t             lb_rd_data;
  logic              lb_wr_en;

  assign col_last = (col_q == COL_W'(WIDTH - 1));
  assign row_last = (row_q == ROW_W'(HEIGHT - 1));
  assign lb_addr  = LB_AW'(col_q >> 1);

  // Pop whenever data exists and the downstream FIFO still has slack.
  assign in_rdreq  = !in_empty && !out_full && !reset;
  assign rd_pend_d = in_rdreq;

  // Raster position of the pixel currently arriving on in_rdata.
  // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (rd_pend_q) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Stage 1 capture: ReLU the arriving pixel and tag it with its position.
  always_comb begin
    s1_d         = '0;
    s1_d.valid   = rd_pend_q;
    s1_d.col_odd = col_q[0];
    s1_d.row_odd = row_q[0];
    s1_d.last    = col_last && row_last;
    s1_d.px      = relu_fp(in_rdata);
    s1_addr_d    = lb_addr;
  end

  // Line-buffer read is launched alongside stage-1 capture so it lines up with stage 1.
  vip_featuremap_line_buffer #(
    .DWIDTH (DWIDTH),
    .DEPTH  (LB_DEPTH),
    .AW     (LB_AW)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (lb_wr_en),
    .wr_addr (s1_addr_q),
    .wr_data (hmax),
    .rd_en   (rd_pend_q),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  // Pooling: hold even columns, fold odd columns, store on even rows, emit on odd rows.
  always_comb begin
    hmax         = max_nonneg_fp(h_q, s1_q.px);
    h_d          = h_q;
    lb_wr_en     = 1'b0;
    out_wrreq_d  = 1'b0;
    frame_done_d = 1'b0;
    out_wdata_d  = out_wdata_q;
    if (s1_q.valid) begin
      if (!s1_q.col_odd) begin
        h_d = s1_q.px;
      end else if (!s1_q.row_odd) begin
        lb_wr_en = 1'b1;
      end else begin
        out_wrreq_d  = 1'b1;
        out_wdata_d  = max_nonneg_fp(lb_rd_data, hmax);
        frame_done_d = s1_q.last;
      end
    end
  end

  // State registers; reset drops any pixel in flight and restarts at (row 0, col 0).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      s1_q         <= '0;
      s1_addr_q    <= '0;
      h_q          <= FP_ZERO;
      out_wdata_q  <= FP_ZERO;
      out_wrreq_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      col_q        <= col_d;
      row_q        <= row_d;
      s1_q         <= s1_d;
      s1_addr_q    <= s1_addr_d;
      h_q          <= h_d;
      out_wdata_q  <= out_wdata_d;
      out_wrreq_q  <= out_wrreq_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_wdata  = out_wdata_q;
  assign out_wrreq  = out_wrreq_q;
  assign frame_done = frame_done_q;

endmodule
